// File: rtl/mips_pipe_pkg.sv
// Opcodes, instruction classes and the decode helper shared by the mips_pipe core.
package mips_pipe_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'd63;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} itype_e;

    // Control carried down the pipe; wen is only set for a nonzero destination.
    typedef struct packed {
        itype_e     itype;
        logic [4:0] dst;
        logic       wen;
    } ctl_t;

    typedef struct packed {
        ctl_t ctl;
        logic use_rs;
        logic use_rt;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d = '0;
        d.ctl.itype = HALT;
        case (ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                d.ctl.itype = RR_ALU;
                d.ctl.dst   = ir[15:11];
                d.use_rs    = 1'b1;
                d.use_rt    = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_SLTI: begin
                d.ctl.itype = RM_ALU;
                d.ctl.dst   = ir[20:16];
                d.use_rs    = 1'b1;
            end
            OP_LW: begin
                d.ctl.itype = LOAD;
                d.ctl.dst   = ir[20:16];
                d.use_rs    = 1'b1;
            end
            OP_SW: begin
                d.ctl.itype = STORE;
                d.use_rs    = 1'b1;
                d.use_rt    = 1'b1;
            end
            OP_BNEQZ, OP_BEQZ: begin
                d.ctl.itype = BRANCH;
                d.use_rs    = 1'b1;
            end
            default: d.ctl.itype = HALT;
        endcase
        d.ctl.wen = (d.ctl.dst != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/mips_pipe_alu.sv
// Combinational XLEN-wide ALU; immediate and memory opcodes map onto their RR counterparts.
module mips_pipe_alu
    import mips_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = a + b;
        case (op)
            OP_SUB, OP_SUBI: y = a - b;
            OP_AND:          y = a & b;
            OP_OR:           y = a | b;
            OP_SLT, OP_SLTI: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL:          y = a * b;
            default:         y = a + b;
        endcase
    end

endmodule

// File: rtl/mips_pipe_core.sv
// Single-clock 5-stage MIPS-style core with interlocks, branch flush and retire counter.
// Define MIPS_PIPE_FORWARD_EN to add EX/MEM and MEM/WB operand forwarding.
module mips_pipe_core
    import mips_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IADDR_W = 10,
    parameter int DADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic               dmem_we,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               halted,
    output logic [31:0]        retired,
    input  logic [4:0]         dbg_raddr,
    output logic [XLEN-1:0]    dbg_rdata
);

    // vld_pipe[0]=IF/ID, [1]=ID/EX, [2]=EX/MEM, [3]=MEM/WB
    logic [3:0]         vld_pipe;
    logic [IADDR_W-1:0] pc, ifid_npc, idex_npc;
    logic [31:0]        ifid_ir;
    logic               stop;
    logic [XLEN-1:0]    regs [32];

    dec_t               id_dec;
    logic [4:0]         id_rs, id_rt;
    logic [XLEN-1:0]    id_a, id_b, id_imm;
    logic               hlt_in_id, ex_hit, stall;

    logic [5:0]         idex_op;
    ctl_t               idex_ctl;
    logic [XLEN-1:0]    idex_a, idex_b, idex_imm;

    logic [XLEN-1:0]    ex_a, ex_b, ex_opb, ex_y;
    logic               ex_taken;
    logic [IADDR_W-1:0] ex_target;

    ctl_t               exmem_ctl;
    logic [XLEN-1:0]    exmem_y, exmem_b;

    ctl_t               memwb_ctl;
    logic [XLEN-1:0]    memwb_res;
    logic               wb_wr;

    assign imem_addr  = pc;
    assign dmem_addr  = exmem_y[DADDR_W-1:0];
    assign dmem_wdata = exmem_b;
    assign dmem_we    = vld_pipe[2] && (exmem_ctl.itype == STORE) && !halted;
    assign dbg_rdata  = regs[dbg_raddr];

    // ID: decode and register read with write-through from WB
    assign id_dec    = decode(ifid_ir);
    assign id_rs     = ifid_ir[25:21];
    assign id_rt     = ifid_ir[20:16];
    assign id_imm    = XLEN'($signed(ifid_ir[15:0]));
    assign wb_wr     = vld_pipe[3] && memwb_ctl.wen && !halted;
    assign id_a      = (wb_wr && memwb_ctl.dst == id_rs) ? memwb_res : regs[id_rs];
    assign id_b      = (wb_wr && memwb_ctl.dst == id_rt) ? memwb_res : regs[id_rt];
    assign hlt_in_id = vld_pipe[0] && (id_dec.ctl.itype == HALT);

    assign ex_hit = vld_pipe[1] && idex_ctl.wen &&
                    ((id_dec.use_rs && idex_ctl.dst == id_rs) ||
                     (id_dec.use_rt && idex_ctl.dst == id_rt));

`ifdef MIPS_PIPE_FORWARD_EN
    logic [4:0] idex_rs, idex_rt;

    assign stall = vld_pipe[0] && ex_hit && (idex_ctl.itype == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_rs <= '0;
            idex_rt <= '0;
        end else if (!halted) begin
            idex_rs <= id_rs;
            idex_rt <= id_rt;
        end
    end

    // Younger EX/MEM result overrides MEM/WB; a load in EX/MEM is covered by the stall.
    always_comb begin
        ex_a = idex_a;
        ex_b = idex_b;
        if (vld_pipe[3] && memwb_ctl.wen && memwb_ctl.dst == idex_rs) ex_a = memwb_res;
        if (vld_pipe[3] && memwb_ctl.wen && memwb_ctl.dst == idex_rt) ex_b = memwb_res;
        if (vld_pipe[2] && exmem_ctl.wen && exmem_ctl.itype != LOAD && exmem_ctl.dst == idex_rs)
            ex_a = exmem_y;
        if (vld_pipe[2] && exmem_ctl.wen && exmem_ctl.itype != LOAD && exmem_ctl.dst == idex_rt)
            ex_b = exmem_y;
    end
`else
    logic mem_hit;

    assign mem_hit = vld_pipe[2] && exmem_ctl.wen &&
                     ((id_dec.use_rs && exmem_ctl.dst == id_rs) ||
                      (id_dec.use_rt && exmem_ctl.dst == id_rt));
    assign stall = vld_pipe[0] && (ex_hit || mem_hit);
    assign ex_a  = idex_a;
    assign ex_b  = idex_b;
`endif

    // EX
    assign ex_opb    = (idex_ctl.itype inside {RM_ALU, LOAD, STORE}) ? idex_imm : ex_b;
    assign ex_taken  = vld_pipe[1] && (idex_ctl.itype == BRANCH) &&
                       ((idex_op == OP_BEQZ) == (ex_a == '0));
    assign ex_target = idex_npc + idex_imm[IADDR_W-1:0];

    mips_pipe_alu #(.XLEN(XLEN)) u_alu (
        .op (idex_op),
        .a  (ex_a),
        .b  (ex_opb),
        .y  (ex_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            vld_pipe  <= '0;
            stop      <= 1'b0;
            halted    <= 1'b0;
            retired   <= '0;
            ifid_ir   <= '0;
            ifid_npc  <= '0;
            idex_op   <= '0;
            idex_ctl  <= '0;
            idex_a    <= '0;
            idex_b    <= '0;
            idex_imm  <= '0;
            idex_npc  <= '0;
            exmem_ctl <= '0;
            exmem_y   <= '0;
            exmem_b   <= '0;
            memwb_ctl <= '0;
            memwb_res <= '0;
        end else if (!halted) begin
            // A taken branch outranks both the interlock and a HLT sitting in ID.
            if (ex_taken) begin
                pc          <= ex_target;
                vld_pipe[0] <= 1'b0;
            end else if (stall) begin
                pc <= pc;
            end else if (stop || hlt_in_id) begin
                vld_pipe[0] <= 1'b0;
            end else begin
                pc          <= pc + 1'b1;
                ifid_ir     <= imem_rdata;
                ifid_npc    <= pc + 1'b1;
                vld_pipe[0] <= 1'b1;
            end
            if (hlt_in_id && !ex_taken) stop <= 1'b1;

            vld_pipe[1] <= vld_pipe[0] && !ex_taken && !stall;
            idex_op     <= ifid_ir[31:26];
            idex_ctl    <= id_dec.ctl;
            idex_a      <= id_a;
            idex_b      <= id_b;
            idex_imm    <= id_imm;
            idex_npc    <= ifid_npc;

            vld_pipe[2] <= vld_pipe[1];
            exmem_ctl   <= idex_ctl;
            exmem_y     <= ex_y;
            exmem_b     <= ex_b;

            vld_pipe[3] <= vld_pipe[2];
            memwb_ctl   <= exmem_ctl;
            memwb_res   <= (exmem_ctl.itype == LOAD) ? dmem_rdata : exmem_y;

            if (vld_pipe[3]) begin
                if (memwb_ctl.itype == HALT) halted <= 1'b1;
                if (retired != '1) retired <= retired + 1'b1;
            end
        end
    end

    // R0 is cleared by reset and never written, so it always reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_wr) begin
            regs[memwb_ctl.dst] <= memwb_res;
        end
    end

endmodule
